// File: rtl/modinv_2909.sv
// ---------------------------------------------------------------------------
// modinv_2909
//   Sequential modular inverter over GF(Q), Q = 2909 (prime). The block
//   computes a^(Q-2) mod Q by left-to-right square-and-multiply. It performs
//   one exact mod-Q reduction of a 24-bit product per cycle. Each operation
//   takes a constant number of cycles, whatever the operand value.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   din_valid   in   din_a is valid
//   din_ready   out  block can accept an operand (IDLE only)
//   din_a       in   W-bit operand, any value 0..2^W-1
//   dout_valid  out  dout_r / dout_zero are valid
//   dout_ready  in   downstream accepts the result
//   dout_r      out  inverse mod Q, range 0..Q-1
//   dout_zero   out  operand was congruent to 0 (no inverse exists)
// ---------------------------------------------------------------------------
module modinv_2909 #(
    parameter int Q = 2909,
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [W-1:0] din_a,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [W-1:0] dout_r,
    output logic         dout_zero
);

    localparam int PW = 2 * W;                        // full product width
    localparam int IW = $clog2(W);                    // bit-index width
    localparam logic [W-1:0]  E   = W'(Q - 2);        // Fermat exponent
    localparam logic [W:0]    MU  = (W+1)'((2 ** PW) / Q); // floor(2^24/Q)
    localparam logic [W-1:0]  QW  = W'(Q);
    localparam logic [PW-1:0] QP  = PW'(Q);
    localparam logic [W+1:0]  QR  = (W+2)'(Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQR,
        S_MUL,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_base;
    logic [IW-1:0]  r_idx;
    logic           r_zero;
    logic           r_din_ready;
    logic           r_dout_valid;
    logic [W-1:0]   r_dout_r;
    logic           r_dout_zero;

    // -----------------------------------------------------------------------
    // Operand pre-reduction: 2^W-1-Q < Q, so one subtraction is enough.
    // -----------------------------------------------------------------------
    logic [W-1:0] w_din_red;
    assign w_din_red = (din_a >= QW) ? (din_a - QW) : din_a;

    // -----------------------------------------------------------------------
    // Shared multiplier. SQR squares the accumulator. MUL multiplies it by
    // the base.
    // -----------------------------------------------------------------------
    logic [W-1:0]    w_opnd;
    logic [PW-1:0]   w_prod;
    logic [PW+W:0]   w_qest_full;
    logic [W:0]      w_q;
    logic [PW-1:0]   w_qq;
    logic [W+1:0]    w_r0;
    logic [W+1:0]    w_r1;
    logic [W+1:0]    w_r2;
    logic [W-1:0]    w_red;

    assign w_opnd = (r_state == S_MUL) ? r_base : r_acc;
    assign w_prod = {{W{1'b0}}, r_acc} * {{W{1'b0}}, w_opnd};

    // Barrett: q = floor(x*mu / 2^24) underestimates floor(x/Q) by at most 2
    // for every x < Q^2. The remainder x - q*Q is therefore below 3Q, and
    // two conditional subtractions make it exact. The remainder fits in
    // W+2 bits, so the upper bits of the difference are known zero.
    assign w_qest_full = {{(W+1){1'b0}}, w_prod} * {{PW{1'b0}}, MU};
    assign w_q         = (W+1)'(w_qest_full >> PW);
    assign w_qq        = {{(PW-W-1){1'b0}}, w_q} * QP;
    assign w_r0        = (W+2)'(w_prod - w_qq);
    assign w_r1        = (w_r0 >= QR) ? (w_r0 - QR) : w_r0;
    assign w_r2        = (w_r1 >= QR) ? (w_r1 - QR) : w_r1;
    assign w_red       = W'(w_r2);

    // -----------------------------------------------------------------------
    // Control FSM with registered handshake outputs. The result registers
    // load on the first DONE cycle. dout_valid therefore rises one edge
    // after the final MUL.
    // -----------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments, so every branch
    // reads the pre-edge values of r_acc/r_idx. Blocking assignments would
    // make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_base       <= '0;
            r_idx        <= '0;
            r_zero       <= 1'b0;
            r_din_ready  <= 1'b1;
            r_dout_valid <= 1'b0;
            r_dout_r     <= '0;
            r_dout_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (din_valid && r_din_ready) begin
                        // Loading the base consumes the exponent MSB.
                        r_base      <= w_din_red;
                        r_acc       <= w_din_red;
                        r_idx       <= IW'(W - 2);
                        r_zero      <= (w_din_red == '0);
                        r_din_ready <= 1'b0;
                        r_state     <= S_SQR;
                    end
                end
                S_SQR: begin
                    r_acc <= w_red;
                    if (E[r_idx]) begin
                        r_state <= S_MUL;
                    end else if (r_idx == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                S_MUL: begin
                    r_acc <= w_red;
                    if (r_idx == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx - IW'(1);
                        r_state <= S_SQR;
                    end
                end
                S_DONE: begin
                    if (!r_dout_valid) begin
                        r_dout_valid <= 1'b1;
                        r_dout_r     <= r_acc;
                        r_dout_zero  <= r_zero;
                    end else if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_din_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign din_ready  = r_din_ready;
    assign dout_valid = r_dout_valid;
    assign dout_r     = r_dout_r;
    assign dout_zero  = r_dout_zero;

endmodule
